// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide blocks:
// FSM state encoding and the default operand width.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep or restore the remainder.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           neg;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor_i};
  // rem < divisor holds on entry, so the extra bit is a true sign
  assign neg     = trial[WIDTH];

  always_comb begin
    rem_o = shifted[WIDTH-1:0];
    if (!neg) begin
      rem_o = trial[WIDTH-1:0];
    end
    quo_o = {quo_i[WIDTH-2:0], ~neg};
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// DIVIDER_DIVZERO_DETECT_EN: finish zero-divisor requests in one cycle.
module iter_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef DIVIDER_DIVZERO_DETECT_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] sr_d;
  logic             zero_det;

  assign zero_det = ZERO_EN && (divisor == '0);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (sr_q),
    .divisor_i(dvs_q),
    .rem_o    (rem_d),
    .quo_o    (sr_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      sr_q        <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
          if (start) begin
            if (zero_det) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              rem_q   <= '0;
              sr_q    <= dividend;
              dvs_q   <= divisor;
              cnt_q   <= CW'(WIDTH);
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q - CW'(1);
          // last step: publish results and pulse done
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= sr_d;
            remainder_q <= rem_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          dbz_q   <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q & ZERO_EN;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: arithmetic reference model compared
// every cycle, plus directed scenarios with literal results.
module tb_iter_divider;

  localparam int W = 4;

`ifdef DIVIDER_DIVZERO_DETECT_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  iter_divider #(
    .WIDTH(W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Model: period index of acceptance/completion and results
  int           acc = -100;
  int           done_per = -100;
  int           busy_end = -100;
  logic [W-1:0] pq = '0;
  logic [W-1:0] pr = '0;
  logic         pz = 1'b0;
  logic [W-1:0] rq = '0;
  logic [W-1:0] rr = '0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      acc      = -100;
      done_per = -100;
      busy_end = -100;
      pz       = 1'b0;
      rq       = '0;
      rr       = '0;
    end else begin
      if (cyc == done_per) begin
        rq = pq;
        rr = pr;
      end
      if (start && cyc > busy_end) begin
        acc = cyc;
        if (divisor == '0) begin
          pq = '1;
          pr = dividend;
        end else begin
          pq = W'(int'(dividend) / int'(divisor));
          pr = W'(int'(dividend) % int'(divisor));
        end
        if (DZ && divisor == '0) begin
          done_per = cyc;
          busy_end = cyc;
          pz       = 1'b1;
          rq       = pq;
          rr       = pr;
        end else begin
          done_per = cyc + W;
          busy_end = cyc + W;
          pz       = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  always begin
    @(negedge clock);
    #1;
    chk("m_busy", busy, int'(cyc >= acc && cyc < done_per));
    chk("m_done", done, int'(cyc == done_per));
    chk("m_dbz", div_by_zero, int'(cyc == done_per && pz));
    chk("m_quo", quotient, rq);
    chk("m_rem", remainder, rr);
  end

  task automatic step(input logic s, input int a, input int b);
    @(negedge clock);
    #2;
    start    = s;
    dividend = W'(a);
    divisor  = W'(b);
    #1;
  endtask

  task automatic chk_bd(input string nm, input logic eb, input logic ed);
    chk({nm, "_busy"}, busy, eb);
    chk({nm, "_done"}, done, ed);
  endtask

  task automatic chk_res(input string nm, input int q, input int r,
                         input logic z);
    chk({nm, "_q"}, quotient, q);
    chk({nm, "_r"}, remainder, r);
    chk({nm, "_dbz"}, div_by_zero, z);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom);
  endtask

  initial begin
    idle(2);
    reset = 1'b0;
    chk_res("rst", 0, 0, 1'b0);
    chk_bd("rst", 1'b0, 1'b0);
    idle(2);

    // 13 / 4
    step(1'b1, 13, 4);
    for (int k = 0; k <= 4; k++) begin
      step(1'b0, $urandom, $urandom);
      chk_bd("d13", k < 4, k == 4);
    end
    chk_res("d13", 3, 1, 1'b0);
    idle(2);

    // 7 / 0
    step(1'b1, 7, 0);
    if (DZ) begin
      step(1'b0, 0, 0);
      chk_bd("dz", 1'b0, 1'b1);
      chk_res("dz", 15, 7, 1'b1);
    end else begin
      for (int k = 0; k <= 4; k++) begin
        step(1'b0, 0, 0);
        chk_bd("dz", k < 4, k == 4);
      end
      chk_res("dz", 15, 7, 1'b0);
    end
    idle(2);

    // start during RUN ignored
    step(1'b1, 9, 2);
    step(1'b0, 0, 0);
    step(1'b1, 15, 3);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    chk_bd("ign", 1'b0, 1'b1);
    chk_res("ign", 4, 1, 1'b0);
    step(1'b0, 0, 0);
    chk_bd("ign5", 1'b0, 1'b0);
    idle(2);

    // reset mid-RUN
    step(1'b1, 14, 5);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_bd("arst", 1'b0, 1'b0);
    chk_res("arst", 0, 0, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 0, 0);
      chk("arst_nodone", done, 0);
    end
    step(1'b1, 14, 5);
    for (int k = 0; k <= 4; k++) begin
      step(1'b0, 0, 0);
      chk_bd("rerun", k < 4, k == 4);
    end
    chk_res("rerun", 2, 4, 1'b0);
    idle(2);

    // start held high across DONE
    step(1'b1, 12, 5);
    for (int k = 0; k <= 4; k++) begin
      step(1'b1, 6, 3);
      chk_bd("b2b1", k < 4, k == 4);
    end
    chk_res("b2b1", 2, 2, 1'b0);
    for (int k = 5; k <= 9; k++) begin
      step(1'b0, 0, 0);
      chk_bd("b2b2", k < 9, k == 9);
    end
    chk_res("b2b2", 2, 0, 1'b0);
    idle(2);

    // exhaustive, back-to-back through DONE
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        step(1'b1, a, b);
        for (int k = 0; k < 4; k++) step(1'b0, $urandom, $urandom);
      end
    end
    idle(3);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        @(negedge clock);
        #2;
        reset = 1'b1;
        start = 1'($urandom_range(0, 1));
        @(negedge clock);
        #2;
        reset = 1'b0;
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 15),
             $urandom_range(0, 15));
      end
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
